// File: rtl/rl_delay_line.sv
// Multi-channel delay line with per-channel runtime depth, valid tags,
// a shared advance enable and a flush that invalidates in-flight samples.
module rl_delay_line #(
  parameter  int WIDTH     = 16,
  parameter  int NCH       = 3,
  parameter  int MAX_DEPTH = 4,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH*DW-1:0]    depth,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH*WIDTH-1:0] dout
);

  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0]     s [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] v;
    logic [DW-1:0]        dq;
    logic [DW-1:0]        dc;
    logic [DW-1:0]        dreq;
    logic [WIDTH-1:0]     sel_d;
    logic                 sel_v;

    assign dc   = depth[c*DW +: DW];
    assign dreq = (dc > DMAX) ? DMAX : dc;

    // Depth change restarts the line; otherwise shift on en, flush kills tags
    always_ff @(posedge clk) begin
      if (rst) begin
        dq <= '0;
        v  <= '0;
        for (int k = 0; k < MAX_DEPTH; k++) begin
          s[k] <= '0;
        end
      end else if (dreq != dq) begin
        dq <= dreq;
        v  <= '0;
      end else if (en) begin
        s[0] <= din[c*WIDTH +: WIDTH];
        v[0] <= in_valid[c] & ~flush;
        for (int k = 1; k < MAX_DEPTH; k++) begin
          s[k] <= s[k-1];
          v[k] <= v[k-1] & ~flush;
        end
      end else if (flush) begin
        v <= '0;
      end
    end

    // Tap select: bypass at depth 0, else a mux over the stage registers
    always_comb begin
      sel_d = din[c*WIDTH +: WIDTH];
      sel_v = in_valid[c];
      for (int k = 0; k < MAX_DEPTH; k++) begin
        if (dq == DW'(k + 1)) begin
          sel_d = s[k];
          sel_v = v[k];
        end
      end
    end

    assign dout[c*WIDTH +: WIDTH] = sel_d;
    assign out_valid[c]           = sel_v;
  end

endmodule

// File: tb/tb_rl_delay_line.sv
// Directed bench for rl_delay_line: latency per depth, en gaps,
// depth switching, flush, clamping, bypass and mid-stream reset.
module tb_rl_delay_line;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int MD = 4;
  localparam int DW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            flush;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  din;
  logic [N*DW-1:0] depth;
  logic [N-1:0]    out_valid;
  logic [N*W-1:0]  dout;

  int checks   = 0;
  int failures = 0;

  rl_delay_line #(.WIDTH(W), .NCH(N), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .din(din), .depth(depth),
    .out_valid(out_valid), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] dch(int c);
    return dout[c*W +: W];
  endfunction

  task automatic set_din(int c, logic [W-1:0] d);
    din[c*W +: W] = d;
  endtask

  task automatic set_depth(int c, logic [DW-1:0] d);
    depth[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    in_valid = '0; din = '0; depth = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=000", out_valid);
    end
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL reset_dout got=%h exp=0", dout);
    end
  endtask

  task automatic test_latency();
    int dd [N];
    logic          ev;
    logic [W-1:0]  ed;
    dd[0] = 1; dd[1] = 2; dd[2] = 4;
    do_reset();
    set_depth(0, 3'd1); set_depth(1, 3'd2); set_depth(2, 3'd4);
    en = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      for (int c = 0; c < N; c++) set_din(c, W'(i + c * 256));
      in_valid = 3'b111;
      tick();
      for (int c = 0; c < N; c++) begin
        ev = (i >= dd[c]);
        ed = W'(i - dd[c] + 1 + c * 256);
        checks++;
        if (out_valid[c] !== ev) begin
          failures++;
          $display("FAIL lat_valid ch=%0d edge=%0d got=%b exp=%b",
                   c, i, out_valid[c], ev);
        end
        if (ev) begin
          checks++;
          if (dch(c) !== ed) begin
            failures++;
            $display("FAIL lat_data ch=%0d edge=%0d got=%h exp=%h",
                     c, i, dch(c), ed);
          end
        end
      end
    end
  endtask

  task automatic test_en_gaps();
    logic [W-1:0] vd [5];
    logic         en_s [5];
    logic         ev [5];
    logic [W-1:0] ed [5];
    vd = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 16'h00EE};
    en_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ed = '{16'h0000, 16'h0000, 16'h00AA, 16'h00AA, 16'h00CC};
    do_reset();
    set_depth(0, 3'd2);
    en = 1'b1;
    tick();
    in_valid = 3'b001;
    for (int i = 0; i < 5; i++) begin
      en = en_s[i];
      set_din(0, vd[i]);
      tick();
      checks++;
      if (out_valid[0] !== ev[i]) begin
        failures++;
        $display("FAIL gap_valid step=%0d got=%b exp=%b",
                 i, out_valid[0], ev[i]);
      end
      if (ev[i]) begin
        checks++;
        if (dch(0) !== ed[i]) begin
          failures++;
          $display("FAIL gap_data step=%0d got=%h exp=%h",
                   i, dch(0), ed[i]);
        end
      end
    end
  endtask

  task automatic test_depth_change();
    do_reset();
    set_depth(0, 3'd3);
    en = 1'b1;
    tick();
    in_valid = 3'b001;
    for (int i = 1; i <= 5; i++) begin
      set_din(0, W'(16'h10 + i));
      tick();
    end
    checks++;
    if (out_valid[0] !== 1'b1 || dch(0) !== 16'h0013) begin
      failures++;
      $display("FAIL dc_pre got=%b/%h exp=1/0013", out_valid[0], dch(0));
    end
    set_depth(0, 3'd1);
    set_din(0, 16'h0020);
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL dc_switch_valid got=%b exp=0", out_valid[0]);
    end
    set_din(0, 16'h0021);
    tick();
    checks++;
    if (out_valid[0] !== 1'b1 || dch(0) !== 16'h0021) begin
      failures++;
      $display("FAIL dc_post got=%b/%h exp=1/0021", out_valid[0], dch(0));
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_depth(0, 3'd4);
    en = 1'b1;
    tick();
    in_valid = 3'b001;
    for (int i = 1; i <= 6; i++) begin
      set_din(0, W'(16'h30 + i));
      tick();
    end
    checks++;
    if (out_valid[0] !== 1'b1 || dch(0) !== 16'h0033) begin
      failures++;
      $display("FAIL fl_pre got=%b/%h exp=1/0033", out_valid[0], dch(0));
    end
    flush = 1'b1;
    set_din(0, 16'h0040);
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL fl_edge got=%b exp=0", out_valid[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      set_din(0, W'(16'h40 + i));
      tick();
      checks++;
      if (out_valid[0] !== (i == 4)) begin
        failures++;
        $display("FAIL fl_valid step=%0d got=%b exp=%b",
                 i, out_valid[0], (i == 4));
      end
    end
    checks++;
    if (dch(0) !== 16'h0041) begin
      failures++;
      $display("FAIL fl_resume got=%h exp=0041", dch(0));
    end
  endtask

  task automatic test_clamp_bypass();
    do_reset();
    set_depth(0, 3'd7);
    en = 1'b1;
    tick();
    in_valid = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      set_din(0, W'(16'h50 + i));
      tick();
      checks++;
      if (out_valid[0] !== (i == 4)) begin
        failures++;
        $display("FAIL clamp_valid step=%0d got=%b exp=%b",
                 i, out_valid[0], (i == 4));
      end
    end
    checks++;
    if (dch(0) !== 16'h0051) begin
      failures++;
      $display("FAIL clamp_data got=%h exp=0051", dch(0));
    end
    set_din(1, 16'h1234);
    in_valid = 3'b011;
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || dch(1) !== 16'h1234) begin
      failures++;
      $display("FAIL bypass_on got=%b/%h exp=1/1234", out_valid[1], dch(1));
    end
    set_din(1, 16'hBEEF);
    in_valid = 3'b001;
    #1;
    checks++;
    if (out_valid[1] !== 1'b0 || dch(1) !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_off got=%b/%h exp=0/beef", out_valid[1], dch(1));
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_depth(0, 3'd2);
    en = 1'b1;
    tick();
    in_valid = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      set_din(0, W'(16'h60 + i));
      tick();
    end
    checks++;
    if (out_valid[0] !== 1'b1 || dch(0) !== 16'h0063) begin
      failures++;
      $display("FAIL mr_pre got=%b/%h exp=1/0063", out_valid[0], dch(0));
    end
    rst = 1'b1;
    in_valid = '0;
    set_din(0, 16'h0000);
    tick();
    checks++;
    if (out_valid[0] !== 1'b0 || dch(0) !== 16'h0000) begin
      failures++;
      $display("FAIL mr_rst got=%b/%h exp=0/0000", out_valid[0], dch(0));
    end
    rst = 1'b0;
    in_valid = 3'b001;
    set_din(0, 16'h0070);
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL mr_load got=%b exp=0", out_valid[0]);
    end
    set_din(0, 16'h0071);
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL mr_cap got=%b exp=0", out_valid[0]);
    end
    set_din(0, 16'h0072);
    tick();
    checks++;
    if (out_valid[0] !== 1'b1 || dch(0) !== 16'h0071) begin
      failures++;
      $display("FAIL mr_first got=%b/%h exp=1/0071", out_valid[0], dch(0));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0;
    in_valid = '0; din = '0; depth = '0;
    test_reset();
    test_latency();
    test_en_gaps();
    test_depth_change();
    test_flush();
    test_clamp_bypass();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rl_delay_line.md
# rl_delay_line

Parametrised multi-channel delay line that aligns action, reward and state samples in the Q-learning datapath. It generalises the fixed two-register delay stages into NCH independent channels. Each channel has a runtime-selectable latency of 0..MAX_DEPTH cycles, a per-sample valid tag, a pipeline-advance enable and a flush. It sits between the action RAM / reward / state producers and the Q-update arithmetic.

## Interface
- WIDTH, 16, data bits per channel
- NCH, 3, number of independent channels
- MAX_DEPTH, 4, maximum delay in cycles (≥1); DW = $clog2(MAX_DEPTH+1) is a derived localparam
- clk  input  1  rising-edge clock; only clock in the block
- rst  input  1  reset, synchronous and active-high
- en  input  1  advance all channels this cycle; 0 = hold
- flush  input  1  invalidate all in-flight samples, all channels
- in_valid  input  NCH  per-channel input sample valid
- din  input  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- depth  input  NCH*DW  requested delay of channel c at [c*DW +: DW]
- out_valid  output  NCH  per-channel delayed valid
- dout  output  NCH*WIDTH  per-channel delayed data, same packing as din

## Operation
- Per channel c: data stages s[1..MAX_DEPTH] (WIDTH bits each), valid bits v[1..MAX_DEPTH], registered depth dq (DW bits).
- Requested depth is clamped: dreq = min(depth_c, MAX_DEPTH).
- Depth change: if dreq != dq at a rising edge, then dq <= dreq and all v[1..MAX_DEPTH] of channel c <= 0. No shift and no capture occur for that channel on that edge, regardless of en. s registers hold. Other channels are unaffected.
- Shift: if en=1, flush=0 and there is no depth change on c: s[1]<=din_c, v[1]<=in_valid[c], s[k]<=s[k-1], v[k]<=v[k-1] for k=2..MAX_DEPTH.
- en=0 and no depth change: all s and v hold.
- flush=1: every v of every channel <= 0; s registers follow normal en shift rules. flush has priority over in_valid, so v[1]=0 even if en=1 and in_valid=1.
- Output, dq=0: combinational bypass, dout_c=din_c and out_valid[c]=in_valid[c].
- Output, dq=d>0: dout_c=s[d] and out_valid[c]=v[d]. This is a mux on registers only; there is no combinational path from din.
- rst (highest priority): all s=0, all v=0, all dq=0.
- Data is passed unmodified; the block performs no width conversion or arithmetic.

## Timing
- Reset values: out_valid=0; dout=0 for dq≥1. With dq=0 after reset, outputs follow din/in_valid combinationally.
- Latency for a channel with dq=d≥1 and en held 1: sample presented at edge n appears on dout at the cycle following edge n+d-1, i.e. exactly d en-cycles later.
- With en gaps, latency counts en=1 edges, not clock cycles.
- After a depth change at edge n, out_valid[c]=0 until d new en-shifts have filled the line. The first valid output comes from a sample captured at edge n+1 or later.
- Depth change and flush on the same edge: both apply, and all v of the affected channel are 0.
- rst asserted mid-stream: outputs are zero/invalid from the next cycle; in-flight samples are lost.
- MAX_DEPTH=1 is legal; the dq choices are 0 and 1 only.

## Test plan
- Reset, then NCH=3 with depths {1,2,4}, en=1, din ramp 0x0001,0x0002,…, in_valid=1: channel 0 outputs 0x0001 one cycle later, channel 1 two cycles later, channel 2 four cycles later. out_valid rises exactly at those cycles.
- depth=2, en toggling 1,0,1,0: 0x00AA appears after two en=1 edges, and dout holds while en=0.
- Steady stream at depth 3, then switch to depth 1 at edge n: out_valid[c]=0 from n+1. Sample from edge n+1 appears valid after edge n+1. Old samples never appear valid.
- Stream at depth 4, assert flush for one cycle with in_valid=1: out_valid=0 for exactly the 4 following en cycles, then resumes. The sample presented during flush is never valid.
- depth=7 with MAX_DEPTH=4: behaves as depth 4. depth=0: dout==din and out_valid==in_valid in the same cycle.
- Assert rst mid-stream at depth 2: out_valid=0 and dout=0 the cycle after. After release, the first valid output arrives two en cycles after the next capture.
